// File: rtl/shadow_dump_collector_pkg.sv
// Shared definitions for the shadow dump collector: sizing helper, FSM encoding
// and the layout of one buffered word.
package shadow_dump_collector_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_DUMP    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A FIFO entry is packed MSB..LSB as {last, nbits, chain, data}.
  function automatic int entry_width(input int word_w, input int cid_w, input int nb_w);
    return 1 + nb_w + cid_w + word_w;
  endfunction

endpackage

// File: rtl/shadow_dump_collector_if.sv
// Host readout stream of the shadow dump collector.
interface shadow_dump_collector_if #(
  parameter int WORD_WIDTH = 8,
  parameter int CID_W      = 1,
  parameter int NB_W       = 4
);
  // A word transfers on every clock edge where out_vld & out_rdy; while out_vld is
  // high and out_rdy low the payload stays stable, and out_vld never drops unaccepted.
  logic                  out_vld;
  logic                  out_rdy;
  logic [WORD_WIDTH-1:0] out_data;
  logic [CID_W-1:0]      out_chain;
  logic [NB_W-1:0]       out_nbits;
  logic                  out_last;

  modport master (output out_vld, out_data, out_chain, out_nbits, out_last, input out_rdy);
  modport slave  (input out_vld, out_data, out_chain, out_nbits, out_last, output out_rdy);
endinterface

// File: rtl/shadow_word_fifo.sv
// First-word fall-through FIFO; rd_data reads as zero while empty.
module shadow_word_fifo
  import shadow_dump_collector_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/shadow_dump_collector.sv
// Root-side collector: pulses capture into the shadow tree, deserializes each chain
// into tagged words and queues them for the host readout stream.
module shadow_dump_collector
  import shadow_dump_collector_pkg::*;
#(
   parameter int CHAINS     = 1,
   parameter int WORD_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              capture_en,
   output logic [CHAINS-1:0] dump_en,
   input  logic [CHAINS-1:0] chains,
   input  logic [CHAINS-1:0] chains_vld,
   input  logic [CHAINS-1:0] chains_done,
   output logic              busy,
   output logic              done,
   output state_e            dbg_state,
   shadow_dump_collector_if.master host
);
   localparam int CID_W = (clog2(CHAINS) < 1) ? 1 : clog2(CHAINS);
   localparam int NB_W  = clog2(WORD_WIDTH + 1);
   localparam int EW    = entry_width(WORD_WIDTH, CID_W, NB_W);

   state_e              state_q, state_d;
   logic [CHAINS-1:0]   fin, hold_full, pend, hold_last, grant;
   logic [WORD_WIDTH-1:0] hold_data [CHAINS];
   logic [NB_W-1:0]     hold_nbits [CHAINS];
   logic [CID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                fifo_full, fifo_empty, all_flushed;
   logic [EW-1:0]       wr_entry, rd_entry;

   for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      logic [WORD_WIDTH-1:0] acc_q, acc_d, hdata_q;
      logic [NB_W-1:0]       cnt_q, hnbits_q;
      logic                  hlast_q, full_q, fin_q, pend_q;
      logic                  accept, word_full, done_take;

      assign dump_en[c] = (state_q == ST_DUMP) & ~fin_q & ~full_q;
      assign accept     = dump_en[c] & chains_vld[c];
      assign acc_d      = acc_q | (WORD_WIDTH'(chains[c]) << cnt_q);
      assign word_full  = accept & (cnt_q == NB_W'(WORD_WIDTH - 1));
      assign done_take  = (state_q == ST_DUMP) & chains_done[c] & ~full_q & ~fin_q;

      // Later assignments win: the done word overrides the plain bit update, and a
      // done that coincides with a full word defers the terminator via pend_q.
      always_ff @(posedge clk) begin
         if (!rst_n || state_q == ST_CAPTURE) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            hdata_q  <= '0;
            hnbits_q <= '0;
            hlast_q  <= 1'b0;
            full_q   <= 1'b0;
            fin_q    <= 1'b0;
            pend_q   <= 1'b0;
         end else begin
            if (grant[c]) full_q <= 1'b0;
            if (accept) begin
               if (word_full) begin
                  hdata_q  <= acc_d;
                  hnbits_q <= NB_W'(WORD_WIDTH);
                  hlast_q  <= 1'b0;
                  full_q   <= 1'b1;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            if (done_take) begin
               fin_q <= 1'b1;
               if (word_full) begin
                  pend_q <= 1'b1;
               end else begin
                  hdata_q  <= accept ? acc_d : acc_q;
                  hnbits_q <= accept ? cnt_q + 1'b1 : cnt_q;
                  hlast_q  <= 1'b1;
                  full_q   <= 1'b1;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            if (pend_q && !full_q) begin
               hdata_q  <= '0;
               hnbits_q <= '0;
               hlast_q  <= 1'b1;
               full_q   <= 1'b1;
               pend_q   <= 1'b0;
            end
         end
      end

      assign fin[c]        = fin_q;
      assign hold_full[c]  = full_q;
      assign pend[c]       = pend_q;
      assign hold_last[c]  = hlast_q;
      assign hold_data[c]  = hdata_q;
      assign hold_nbits[c] = hnbits_q;
   end

   // Round-robin: first search from the pointer upward, then wrap to the low indices.
   always_comb begin
      grant    = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < CHAINS; k++) begin
         if (grant == '0 && hold_full[k] && k >= int'(rr_ptr_q)) begin
            grant[k] = 1'b1;
            rr_ptr_d = (k == CHAINS - 1) ? '0 : CID_W'(k + 1);
         end
      end
      for (int k = 0; k < CHAINS; k++) begin
         if (grant == '0 && hold_full[k]) begin
            grant[k] = 1'b1;
            rr_ptr_d = (k == CHAINS - 1) ? '0 : CID_W'(k + 1);
         end
      end
      if (fifo_full) begin
         grant    = '0;
         rr_ptr_d = rr_ptr_q;
      end
   end

   always_comb begin
      wr_entry = '0;
      for (int k = 0; k < CHAINS; k++) begin
         if (grant[k]) wr_entry = {hold_last[k], hold_nbits[k], CID_W'(k), hold_data[k]};
      end
   end

   assign all_flushed = (&fin) & ~(|hold_full) & ~(|pend);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_DUMP;
         ST_DUMP:    if (all_flushed) state_d = ST_DRAIN;
         ST_DRAIN:   if (fifo_empty) state_d = ST_DONE;
         ST_DONE:    if (start) state_d = ST_CAPTURE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   shadow_word_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (|grant),
      .wr_data (wr_entry),
      .full    (fifo_full),
      .rd_en   (host.out_vld & host.out_rdy),
      .rd_data (rd_entry),
      .empty   (fifo_empty)
   );

   assign host.out_vld = ~fifo_empty;
   assign {host.out_last, host.out_nbits, host.out_chain, host.out_data} = rd_entry;

   assign capture_en = (state_q == ST_CAPTURE);
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_shadow_dump_collector.sv
// Randomized bench for shadow_dump_collector: per-chain word lists computed from
// the bit streams are compared against the host readout stream.
module tb_shadow_dump_collector;
   import shadow_dump_collector_pkg::*;

   localparam int CHAINS = 2;
   localparam int WW     = 8;
   localparam int DEPTH  = 2;

   logic              clk, rst_n, start;
   logic              capture_en, busy, done;
   logic [CHAINS-1:0] dump_en, chains, chains_vld, chains_done;
   state_e            dbg_state;

   shadow_dump_collector_if #(.WORD_WIDTH(WW), .CID_W(1), .NB_W(4)) host_if ();

   shadow_dump_collector #(.CHAINS(CHAINS), .WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .capture_en  (capture_en),
      .dump_en     (dump_en),
      .chains      (chains),
      .chains_vld  (chains_vld),
      .chains_done (chains_done),
      .busy        (busy),
      .done        (done),
      .dbg_state   (dbg_state),
      .host        (host_if)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // scoreboard: one expected queue per chain, entries {last, nbits[3:0], data[7:0]}
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];
   int          order_c[$];
   logic [7:0]  order_d[$];
   logic [63:0] bits_v [CHAINS];
   int          len [CHAINS];
   int          idx [CHAINS];
   int          stall [CHAINS];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void push_exp(input int c, input logic [12:0] v);
      if (c == 0) exp_q0.push_back(v);
      else exp_q1.push_back(v);
   endfunction

   // Reference: whole 8-bit words LSB-first, then one final word holding the remainder.
   task automatic build_expected(input int c);
      int         pos, rem;
      logic [7:0] w, mask;
      pos = 0;
      while (len[c] - pos >= WW) begin
         w = bits_v[c][pos +: 8];
         push_exp(c, {1'b0, 4'd8, w});
         pos += WW;
      end
      rem  = len[c] - pos;
      mask = 8'((1 << rem) - 1);
      w    = bits_v[c][pos +: 8] & mask;
      push_exp(c, {1'b1, 4'(rem), w});
   endtask

   task automatic sb_pop();
      int          c;
      logic [12:0] got, exp;
      c   = int'(host_if.out_chain);
      got = {host_if.out_last, host_if.out_nbits, host_if.out_data};
      order_c.push_back(c);
      order_d.push_back(host_if.out_data);
      if (c == 0) begin
         check_eq("avail_c0", exp_q0.size() > 0, 1);
         if (exp_q0.size() > 0) begin
            exp = exp_q0.pop_front();
            check_eq("word_c0", got, exp);
         end
      end else begin
         check_eq("avail_c1", exp_q1.size() > 0, 1);
         if (exp_q1.size() > 0) begin
            exp = exp_q1.pop_front();
            check_eq("word_c1", got, exp);
         end
      end
   endtask

   // driver tasks
   task automatic apply_reset();
      rst_n = 1'b0;
      start = 1'b0;
      chains = '0;
      chains_vld = '0;
      chains_done = '0;
      host_if.out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_case(input int l0, input int l1, input int vld_pct, input int rdy_pct,
                           input bit simul, input bit start_poke, input int rdy_block);
      int          cycles, caps;
      bit          finished, stalled_prev;
      logic [13:0] head_prev;
      len[0] = l0;
      len[1] = l1;
      exp_q0.delete();
      exp_q1.delete();
      order_c.delete();
      order_d.delete();
      for (int c = 0; c < CHAINS; c++) begin
         idx[c]   = 0;
         stall[c] = 0;
         build_expected(c);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("capture_en_hi", capture_en, 1);
      check_eq("state_capture", dbg_state, ST_CAPTURE);
      @(negedge clk);
      cycles = 0;
      caps = 0;
      finished = 1'b0;
      stalled_prev = 1'b0;
      head_prev = '0;
      while (!finished && cycles < 3000) begin
         for (int c = 0; c < CHAINS; c++) begin
            if (idx[c] < len[c]) begin
               chains_vld[c]  = ($urandom_range(99) < vld_pct);
               chains[c]      = bits_v[c][idx[c]];
               chains_done[c] = simul && chains_vld[c] && (idx[c] == len[c] - 1);
            end else begin
               chains_vld[c]  = 1'b0;
               chains[c]      = 1'b0;
               chains_done[c] = !(c == 1 && cycles < rdy_block);
            end
         end
         host_if.out_rdy = (cycles >= rdy_block) && ($urandom_range(99) < rdy_pct);
         start = start_poke && (dbg_state == ST_DUMP) && ($urandom_range(3) == 0);
         #4;
         if (stalled_prev)
            check_eq("head_stable", {host_if.out_vld, host_if.out_last, host_if.out_nbits,
                                     host_if.out_data}, head_prev);
         stalled_prev = host_if.out_vld && !host_if.out_rdy;
         head_prev = {host_if.out_vld, host_if.out_last, host_if.out_nbits, host_if.out_data};
         if (rdy_block > 0 && cycles == rdy_block - 1) begin
            check_eq("bp_bits_accepted", idx[0], 24);
            check_eq("bp_dump_en_low", dump_en[0], 0);
         end
         for (int c = 0; c < CHAINS; c++) begin
            if (dbg_state == ST_DUMP && !dump_en[c] && idx[c] < len[c]) stall[c]++;
            if (dump_en[c] && chains_vld[c]) idx[c]++;
         end
         if (host_if.out_vld && host_if.out_rdy) sb_pop();
         if (capture_en) caps++;
         if (dbg_state == ST_DONE) finished = 1'b1;
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      chains_vld = '0;
      chains_done = '0;
      host_if.out_rdy = 1'b0;
      check_eq("reached_done", finished, 1);
      check_eq("done_flag", done, 1);
      check_eq("busy_low", busy, 0);
      check_eq("out_vld_low", host_if.out_vld, 0);
      check_eq("no_recapture", caps, 0);
      check_eq("left_c0", exp_q0.size(), 0);
      check_eq("left_c1", exp_q1.size(), 0);
      check_eq("bits_c0", idx[0], len[0]);
      check_eq("bits_c1", idx[1], len[1]);
   endtask

   task automatic reset_mid_dump();
      int n_acc, budget;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_acc = 0;
      budget = 0;
      while (n_acc < 5 && budget < 50) begin
         chains_vld = 2'b01;
         chains[0] = 1'($urandom_range(1));
         #4;
         if (dump_en[0]) n_acc++;
         @(negedge clk);
         budget++;
      end
      check_eq("rst_pre_bits", n_acc, 5);
      rst_n = 1'b0;
      chains_vld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_dump_en", dump_en, 0);
      check_eq("rst_out_vld", host_if.out_vld, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_state", dbg_state, ST_IDLE);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("rst_cap_hi", capture_en, 1);
      @(negedge clk);
      check_eq("rst_cap_lo", capture_en, 0);
      check_eq("rst_state_dump", dbg_state, ST_DUMP);
   endtask

   initial begin
      apply_reset();
      check_eq("reset_state", dbg_state, ST_IDLE);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_capture", capture_en, 0);
      check_eq("reset_dump_en", dump_en, 0);
      check_eq("reset_out_vld", host_if.out_vld, 0);
      check_eq("reset_out_data", host_if.out_data, 0);

      // single chain, 8 bits 1,0,1,1,0,0,0,1 -> 0x8D then empty terminator
      bits_v[0] = 64'h8D;
      bits_v[1] = '0;
      run_case(8, 0, 100, 100, 1'b0, 1'b0, 0);

      // partial final word: 11 ones -> 0xFF/8 then 0x07/3
      bits_v[0] = 64'h7FF;
      run_case(11, 0, 100, 100, 1'b0, 1'b0, 0);

      // two chains in lockstep: chain0 granted first, chain1 waits one more cycle
      apply_reset();
      bits_v[0] = 64'h5AA5;
      bits_v[1] = 64'hC33C;
      run_case(16, 16, 100, 100, 1'b0, 1'b0, 0);
      check_eq("rr_first_chain", order_c[0], 0);
      check_eq("rr_first_data", order_d[0], 8'hA5);
      check_eq("rr_second_chain", order_c[1], 1);
      check_eq("rr_second_data", order_d[1], 8'h3C);
      check_eq("stall_c0", stall[0], 1);
      check_eq("stall_c1", stall[1], 2);

      // backpressure: host stalled, three words fit before shifting stops
      bits_v[0] = {$urandom, $urandom};
      run_case(32, 0, 100, 100, 1'b0, 1'b0, 40);

      // last bit coincides with done, and start pokes during the dump
      bits_v[0] = {$urandom, $urandom};
      bits_v[1] = {$urandom, $urandom};
      run_case(8, 16, 70, 60, 1'b1, 1'b1, 0);

      reset_mid_dump();
      apply_reset();

      for (int r = 0; r < 8; r++) begin
         bits_v[0] = {$urandom, $urandom};
         bits_v[1] = {$urandom, $urandom};
         run_case($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(30, 100),
                  $urandom_range(20, 100), 1'($urandom_range(1)), 1'b1, 0);
      end

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
